snax_alu_pe_driver: RTL
=======================

Name: snax_alu_pe_driver

Overview:
- Sequencer that sits in front of and behind one snax_alu_pe and drives both ends of its stream interface.
- Front end: accepts packed operand pairs from the streamer and presents them on the PE a/b ports. It also drives the PE acc_ready and alu_config inputs.
- Back end: sinks the PE c stream into a small result FIFO. It then forwards results to the result streamer.
- Runs one job of len_i operations per start_i and signals completion with done_o.

Parameters:
- DataWidth, 64, width of each operand (a, b).
- CntWidth, 16, width of the job length and the internal counters.
- ResDepth, 2, result FIFO depth in entries (>=2, power of two).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start a job (sampled in IDLE only)
- len_i  in  CntWidth  number of operations in the job
- alu_config_i  in  2  operation: 0 add, 1 sub, 2 mul, 3 xor
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle completion pulse
- opnd_i  in  2*DataWidth  packed operands {b, a}, a in low half
- opnd_valid_i  in  1  operand valid
- opnd_ready_o  out  1  operand ready
- pe_a_o, pe_b_o  out  DataWidth  operands to PE
- pe_a_valid_o, pe_b_valid_o  out  1  operand valid to PE
- pe_a_ready_i, pe_b_ready_i  in  1  PE operand ready
- pe_c_i  in  2*DataWidth  PE result
- pe_c_valid_i  in  1  PE result valid
- pe_c_ready_o  out  1  result ready to PE
- pe_acc_ready_o  out  1  PE enable (drives PE acc_ready_i)
- pe_alu_config_o  out  2  latched operation to PE
- res_o  out  2*DataWidth  result to streamer
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result ready

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset effects:
  - state = IDLE; issue_cnt, res_cnt and FIFO pointers/count are cleared.
  - FIFO is flushed.
  - pe_alu_config_o = 0.
  - Every valid, ready, busy and done output is 0.
- State IDLE:
  - start_i=1 latches len_i and alu_config_i (latched config drives pe_alu_config_o until the next start) and clears both counters.
  - Next state is RUN if len_i != 0, otherwise DONE.
- State RUN:
  - Define issuing = (issue_cnt < len).
  - pe_acc_ready_o = issuing.
  - pe_a_o and pe_b_o are taken from opnd_i.
  - pe_a_valid_o = pe_b_valid_o = opnd_valid_i && issuing.
  - opnd_ready_o = issuing && pe_a_ready_i && pe_b_ready_i.
  - An operand handshake increments issue_cnt.
  - When res_cnt reaches len on a res handshake, next state is DONE.
- State DONE: done_o=1 for exactly one cycle, then IDLE.
- busy_o = 1 in RUN.
- start_i is ignored outside IDLE. alu_config_i changes during RUN have no effect.
- Combinational paths: pe_*_valid_o must not depend on pe_*_ready_i or pe_c_ready_o. pe_c_ready_o must be a function of registered state only. This keeps the loop through the PE combinational-loop-free.
- Result FIFO:
  - pe_c_ready_o = (state == RUN) && (count < ResDepth).
  - Push on pe_c_valid_i && pe_c_ready_o.
  - res_valid_o = (count != 0); res_o = head entry.
  - Pop on res_valid_o && res_ready_i; each pop increments res_cnt.
  - No fall-through: a pushed entry is visible on res_o the cycle after the push.
  - Simultaneous push and pop in the same cycle leaves count unchanged.
  - When full, no push occurs even if a pop happens the same cycle, because ready is registered.
  - Read and write pointers wrap modulo ResDepth.
- Width rules:
  - Results are stored unmodified at full 2*DataWidth width.
  - The 2*DataWidth result width covers the full product for mul and sign or zero extension for the other operations, as computed by the PE.
  - Counters never exceed len, so there is no overflow.
- Latency: an operand handshake in cycle N gives res_valid_o=1 in cycle N+1. With res_ready_i held at 1, throughput is one result per cycle.
- Backpressure: at most ResDepth operations can be outstanding.
- Asynchronous reset asserted mid-job aborts the job immediately. In-flight results are discarded and no done_o pulse is produced.

Test Plan:
1. Add, no backpressure. Start len=4, config=0, a=0..3, b=10, res_ready=1.
   - Required: res 10,11,12,13 in consecutive cycles.
   - Required: done_o pulse one cycle after the 4th res handshake.
   - Required: busy_o high throughout RUN.
2. Backpressure. res_ready=0, len=4, operands always valid.
   - Required: exactly 2 operand handshakes, then opnd_ready_o=0 and pe_c_ready_o=0.
   - Then raise res_ready: all 4 results arrive in order, then done_o.
3. Zero-length job. Start len=0.
   - Required: done_o high on the next cycle.
   - Required: pe_a_valid_o, pe_acc_ready_o and res_valid_o stay 0.
4. Mul, full width. config=2, a=b=0xFFFFFFFFFFFFFFFF, len=1.
   - Required: res_o = 0xFFFFFFFFFFFFFFFE0000000000000001.
5. Ignored inputs during RUN. Pulse start_i with len=7 and change alu_config_i to 3 during a len=3 sub job (a=9, b=4).
   - Required: exactly 3 results, each 5; pe_alu_config_o stays 1.
6. Reset mid-job. Assert rst_i after 2 of 6 results.
   - Required: all outputs 0 and FIFO empty.
   - Required: a new len=2 add job afterwards produces correct results and one done_o pulse.

Source files
------------

// File: rtl/snax_alu_pe_driver.sv
// Job sequencer around one snax_alu_pe: feeds packed operand pairs into the PE
// and buffers PE results in a small FIFO before handing them to the result streamer.
module snax_alu_pe_driver #(
   parameter int unsigned DataWidth = 64,
   parameter int unsigned CntWidth  = 16,
   parameter int unsigned ResDepth  = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [CntWidth-1:0]    len_i,
   input  logic [1:0]             alu_config_i,
   output logic                   busy_o,
   output logic                   done_o,
   input  logic [2*DataWidth-1:0] opnd_i,
   input  logic                   opnd_valid_i,
   output logic                   opnd_ready_o,
   output logic [DataWidth-1:0]   pe_a_o,
   output logic [DataWidth-1:0]   pe_b_o,
   output logic                   pe_a_valid_o,
   output logic                   pe_b_valid_o,
   input  logic                   pe_a_ready_i,
   input  logic                   pe_b_ready_i,
   input  logic [2*DataWidth-1:0] pe_c_i,
   input  logic                   pe_c_valid_i,
   output logic                   pe_c_ready_o,
   output logic                   pe_acc_ready_o,
   output logic [1:0]             pe_alu_config_o,
   output logic [2*DataWidth-1:0] res_o,
   output logic                   res_valid_o,
   input  logic                   res_ready_i
);
   // state   | meaning
   // ST_IDLE | waiting for start_i
   // ST_RUN  | issuing operands and draining results
   // ST_DONE | one-cycle completion pulse
   localparam int unsigned PtrWidth   = (ResDepth > 1) ? $clog2(ResDepth) : 1;
   localparam int unsigned CountWidth = $clog2(ResDepth + 1);
   localparam logic [CountWidth-1:0] Depth = CountWidth'(ResDepth);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

   state_e                 state_q, state_d;
   logic [CntWidth-1:0]    len_q, len_d;
   logic [CntWidth-1:0]    issue_cnt_q, issue_cnt_d;
   logic [CntWidth-1:0]    res_cnt_q, res_cnt_d;
   logic [1:0]             cfg_q, cfg_d;
   logic [PtrWidth-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CountWidth-1:0]  count_q, count_d;
   logic [2*DataWidth-1:0] mem_q [ResDepth];
   logic [2*DataWidth-1:0] mem_d [ResDepth];
   logic                   run, issuing, opnd_hs, push, pop;

   assign run     = (state_q == ST_RUN);
   assign issuing = run && (issue_cnt_q < len_q);

   // Operand valid is never gated by PE ready, and c ready is purely registered,
   // so no combinational loop can form through the PE.
   assign pe_a_o          = run ? opnd_i[DataWidth-1:0] : '0;
   assign pe_b_o          = run ? opnd_i[2*DataWidth-1:DataWidth] : '0;
   assign pe_a_valid_o    = opnd_valid_i && issuing;
   assign pe_b_valid_o    = opnd_valid_i && issuing;
   assign pe_acc_ready_o  = issuing;
   assign opnd_ready_o    = issuing && pe_a_ready_i && pe_b_ready_i;
   assign pe_c_ready_o    = run && (count_q < Depth);
   assign pe_alu_config_o = cfg_q;
   assign res_valid_o     = (count_q != '0);
   assign res_o           = mem_q[rd_ptr_q];
   assign busy_o          = run;
   assign done_o          = (state_q == ST_DONE);

   assign opnd_hs = opnd_valid_i && opnd_ready_o;
   assign push    = pe_c_valid_i && pe_c_ready_o;
   assign pop     = res_valid_o && res_ready_i;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cfg_d       = cfg_q;
      issue_cnt_d = issue_cnt_q;
      res_cnt_d   = res_cnt_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      mem_d       = mem_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               len_d       = len_i;
               cfg_d       = alu_config_i;
               issue_cnt_d = '0;
               res_cnt_d   = '0;
               state_d     = (len_i != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (opnd_hs) issue_cnt_d = issue_cnt_q + CntWidth'(1);
            if (pop) begin
               res_cnt_d = res_cnt_q + CntWidth'(1);
               if (res_cnt_q + CntWidth'(1) == len_q) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (push) begin
         mem_d[wr_ptr_q] = pe_c_i;
         wr_ptr_d        = wr_ptr_q + PtrWidth'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrWidth'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CountWidth'(1);
         2'b01:   count_d = count_q - CountWidth'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         cfg_q       <= '0;
         issue_cnt_q <= '0;
         res_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         mem_q       <= '{default: '0};
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cfg_q       <= cfg_d;
         issue_cnt_q <= issue_cnt_d;
         res_cnt_q   <= res_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         mem_q       <= mem_d;
      end
   end
endmodule
